// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8N1 UART receiver with oversampled start, data and stop
// detection, break handling and a valid/ready output holding register.
module uart_rx_ctrl #(
    parameter int CLK_HZ       = 65_000_000,
    parameter int BAUD_RATE    = 9600,
    parameter int SAMP_PER_BIT = 16
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    input  logic       ready_in,
    output logic       frame_err_out,
    output logic       overrun_err_out,
    output logic       busy_out
);

    localparam int DIV = CLK_HZ / (SAMP_PER_BIT * BAUD_RATE);
    localparam int SW  = $clog2(SAMP_PER_BIT);

    localparam logic [15:0]   DIV_M1    = 16'(DIV - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(SAMP_PER_BIT - 1);
    localparam logic [SW-1:0] SAMP_MID  = SW'(SAMP_PER_BIT / 2 - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    logic          rx_meta;
    logic          rx_s;
    logic [15:0]   tick_cnt;
    logic          tick;
    logic [2:0]    state;
    logic [SW-1:0] samp_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_q;
    logic          samp_end;
    logic          stop_tick;
    logic          byte_done;
    logic          frame_bad;

    assign tick      = (tick_cnt == 16'd0);
    assign samp_end  = (samp_cnt == SAMP_LAST);
    assign stop_tick = tick && (state == ST_STOP) && samp_end;
    assign byte_done = stop_tick && rx_s;
    assign frame_bad = stop_tick && !rx_s;

    // Two-flop synchronizer; idle-high reset so reset never looks like a start bit
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    // Free-running oversample tick divider, never realigned to frames
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tick_cnt <= DIV_M1;
        end else if (tick) begin
            tick_cnt <= DIV_M1;
        end else begin
            tick_cnt <= tick_cnt - 16'd1;
        end
    end

    // Receive FSM: advances and samples only on tick cycles
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state    <= ST_IDLE;
            samp_cnt <= '0;
            bit_cnt  <= 3'd0;
            shift_q  <= 8'h00;
        end else if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state    <= ST_START;
                        samp_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (samp_cnt == SAMP_MID) begin
                        samp_cnt <= '0;
                        if (!rx_s) begin
                            state   <= ST_DATA;
                            bit_cnt <= 3'd0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        samp_cnt <= samp_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (samp_end) begin
                        samp_cnt <= '0;
                        shift_q  <= {rx_s, shift_q[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        samp_cnt <= samp_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (samp_end) begin
                        samp_cnt <= '0;
                        state    <= rx_s ? ST_IDLE : ST_WAIT_HIGH;
                    end else begin
                        samp_cnt <= samp_cnt + 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    samp_cnt <= '0;
                end
            endcase
        end
    end

    // Output holding register with handshake, overrun and frame-error pulses
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            data_out        <= 8'h00;
            valid_out       <= 1'b0;
            frame_err_out   <= 1'b0;
            overrun_err_out <= 1'b0;
        end else begin
            frame_err_out   <= frame_bad;
            overrun_err_out <= 1'b0;
            if (byte_done) begin
                if (!valid_out || ready_in) begin
                    data_out  <= shift_q;
                    valid_out <= 1'b1;
                end else begin
                    overrun_err_out <= 1'b1;
                end
            end else if (valid_out && ready_in) begin
                valid_out <= 1'b0;
            end
        end
    end

    // Busy flag registered from the FSM state
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_out <= 1'b0;
        end else begin
            busy_out <= (state != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl with a transaction-level
// reference model (sent bytes, handshake occupancy) and a decoupled monitor.
module tb_uart_rx_ctrl;

    localparam int BIT_CLKS = 160;

    localparam logic [1:0] K_DATA = 2'd0;
    localparam logic [1:0] K_FERR = 2'd1;
    localparam logic [1:0] K_OVR  = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       rx_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       ready_in;
    logic       frame_err_out;
    logic       overrun_err_out;
    logic       busy_out;

    int  total;
    int  bad;
    ev_t expq[$];
    bit  m_valid;

    logic       pv;
    logic       pacc;
    logic [7:0] pdata;

    uart_rx_ctrl #(
        .CLK_HZ      (1_600_000),
        .BAUD_RATE   (10_000),
        .SAMP_PER_BIT(16)
    ) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .rx_in          (rx_in),
        .data_out       (data_out),
        .valid_out      (valid_out),
        .ready_in       (ready_in),
        .frame_err_out  (frame_err_out),
        .overrun_err_out(overrun_err_out),
        .busy_out       (busy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    // Reference model: a completed byte is presented if the holding slot is
    // free or being emptied in that same cycle, otherwise it is an overrun.
    task automatic m_done(input logic [7:0] b, input bit rdy);
        ev_t e;
        if (!m_valid || rdy) begin
            e.kind = K_DATA;
            e.data = b;
            m_valid = 1'b1;
        end else begin
            e.kind = K_OVR;
            e.data = 8'h00;
        end
        expq.push_back(e);
    endtask

    task automatic m_ferr();
        ev_t e;
        e.kind = K_FERR;
        e.data = 8'h00;
        expq.push_back(e);
    endtask

    task automatic line(input logic v, input int n);
        rx_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        line(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) line(b[i], BIT_CLKS);
        line(stop_v, BIT_CLKS);
    endtask

    task automatic check_ev(input logic [1:0] k, input logic [7:0] d);
        ev_t e;
        total++;
        if (expq.size() == 0) begin
            bad++;
            $display("FAIL event: unexpected kind=%0d data=%h", k, d);
        end else begin
            e = expq.pop_front();
            if (e.kind != k || (k == K_DATA && e.data != d)) begin
                bad++;
                $display("FAIL event: got kind=%0d data=%h want kind=%0d data=%h",
                         k, d, e.kind, e.data);
            end
        end
    endtask

    // Monitor: pops the scoreboard on every observable DUT event
    initial begin
        pv    = 1'b0;
        pacc  = 1'b0;
        pdata = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (frame_err_out) check_ev(K_FERR, 8'h00);
                if (overrun_err_out) check_ev(K_OVR, 8'h00);
                if (valid_out && (!pv || pacc)) begin
                    check_ev(K_DATA, data_out);
                end else if (valid_out && pv) begin
                    chk("hold_stable", data_out, pdata);
                end
            end
            pv    = valid_out;
            pacc  = valid_out && ready_in;
            pdata = data_out;
        end
    end

    initial begin
        logic [7:0] b;
        bit         seen;
        bit         found;
        total    = 0;
        bad      = 0;
        m_valid  = 1'b0;
        rst_n    = 1'b0;
        rx_in    = 1'b1;
        ready_in = 1'b1;

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 8'(valid_out), 8'h0);
        chk("rst_data", data_out, 8'h00);
        chk("rst_busy", 8'(busy_out), 8'h0);
        chk("rst_errs", 8'({frame_err_out, overrun_err_out}), 8'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        line(1'b1, 50);

        // Directed 0xA5 with ready held high
        m_done(8'hA5, 1'b1);
        m_valid = 1'b0;
        send_frame(8'hA5, 1'b1);
        line(1'b1, 20);

        // Random bytes, random idle gaps, consumer always ready
        for (int n = 0; n < 8; n++) begin
            b = 8'($urandom_range(0, 255));
            m_done(b, 1'b1);
            m_valid = 1'b0;
            send_frame(b, 1'b1);
            line(1'b1, $urandom_range(1, 300));
        end

        // Short low glitch: busy pulses, nothing is reported
        seen  = 1'b0;
        rx_in = 1'b0;
        for (int i = 0; i < 140; i++) begin
            if (i == 40) rx_in = 1'b1;
            @(negedge clk);
            if (busy_out) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("glitch_busy_seen", 8'(seen), 8'h1);
        line(1'b1, 60);
        @(negedge clk);
        chk("glitch_busy_low", 8'(busy_out), 8'h0);
        @(posedge clk);
        #1;

        // Frame error followed by a break
        m_ferr();
        send_frame(8'h3C, 1'b0);
        line(1'b0, 5 * BIT_CLKS);
        @(negedge clk);
        chk("break_busy", 8'(busy_out), 8'h1);
        chk("break_valid", 8'(valid_out), 8'h0);
        @(posedge clk);
        #1;
        line(1'b1, 40);
        @(negedge clk);
        chk("break_end_busy", 8'(busy_out), 8'h0);
        @(posedge clk);
        #1;

        // Overrun: consumer stalled across two frames
        ready_in = 1'b0;
        m_done(8'h11, 1'b0);
        send_frame(8'h11, 1'b1);
        line(1'b1, 40);
        m_done(8'h22, 1'b0);
        send_frame(8'h22, 1'b1);
        line(1'b1, 40);
        @(negedge clk);
        chk("ovr_data", data_out, 8'h11);
        chk("ovr_valid", 8'(valid_out), 8'h1);
        @(posedge clk);
        #1 ready_in = 1'b1;
        m_valid = 1'b0;
        @(posedge clk);
        #1 ready_in = 1'b0;
        @(negedge clk);
        chk("accept_clears", 8'(valid_out), 8'h0);
        @(posedge clk);
        #1;

        // Back-to-back frames; ready only in the completion cycle of the second
        m_done(8'h55, 1'b0);
        m_done(8'h66, 1'b1);
        fork
            begin
                send_frame(8'h55, 1'b1);
                send_frame(8'h66, 1'b1);
                line(1'b1, 40);
            end
            begin
                found = 1'b0;
                for (int i = 0; i < 4000 && !found; i++) begin
                    @(negedge clk);
                    if (valid_out) found = 1'b1;
                end
                total++;
                if (!found) begin
                    bad++;
                    $display("FAIL b2b_first_valid: got=timeout want=valid");
                end else begin
                    repeat (10 * BIT_CLKS - 1) @(posedge clk);
                    #1 ready_in = 1'b1;
                    @(posedge clk);
                    #1 ready_in = 1'b0;
                end
            end
        join
        @(negedge clk);
        chk("b2b_data", data_out, 8'h66);
        chk("b2b_valid", 8'(valid_out), 8'h1);
        @(posedge clk);
        #1 ready_in = 1'b1;
        m_valid = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of bit 4 of 0xF0, then 0x0F
        line(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) line(1'b0, BIT_CLKS);
        line(1'b1, BIT_CLKS / 2);
        @(negedge clk);
        chk("pre_rst_busy", 8'(busy_out), 8'h1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_data", data_out, 8'h00);
        chk("mid_rst_busy", 8'(busy_out), 8'h0);
        chk("mid_rst_flags", 8'({valid_out, frame_err_out, overrun_err_out}), 8'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        line(1'b1, BIT_CLKS / 2 - 3);
        line(1'b1, 4 * BIT_CLKS);
        line(1'b1, 100);
        m_done(8'h0F, 1'b1);
        m_valid = 1'b0;
        send_frame(8'h0F, 1'b1);
        line(1'b1, 100);

        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL pending_events: got=%0d want=0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
